// File: rtl/mul_seq_if.sv
// Request/result bundle between the control unit (master) and the sequential multiplier (slave).
interface mul_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op_a, op_b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op_a, op_b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_seq_unit.sv
// Sequential shift-add multiplier with HI/LO result registers, one iteration per cycle.
// Optional SIGNED_MUL_EN macro selects a two's-complement multiply (sign-magnitude around the unsigned core).
module mul_seq_unit #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    mul_seq_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [2*WIDTH-1:0] ZERO_P = '0;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [2*WIDTH:0]   addend;
    logic [2*WIDTH:0]   sum;
    logic [2*WIDTH:0]   shifted;
    logic [2*WIDTH-1:0] result;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    // Multiplicand is added at bit WIDTH; the carry lands in the extra top bit and is shifted back in.
    assign addend  = mplier_q[0] ? {1'b0, mcand_q, {WIDTH{1'b0}}} : '0;
    assign sum     = acc_q + addend;
    assign shifted = sum >> 1;

`ifdef SIGNED_MUL_EN
    logic sign_q, sign_d;
    logic [WIDTH-1:0] zero_w;

    assign zero_w = '0;
    // The most-negative operand negates to itself, which is the correct unsigned magnitude.
    assign mag_a  = bus.op_a[WIDTH-1] ? (zero_w - bus.op_a) : bus.op_a;
    assign mag_b  = bus.op_b[WIDTH-1] ? (zero_w - bus.op_b) : bus.op_b;
    assign result = sign_q ? (ZERO_P - shifted[2*WIDTH-1:0]) : shifted[2*WIDTH-1:0];
`else
    assign mag_a  = bus.op_a;
    assign mag_b  = bus.op_b;
    assign result = shifted[2*WIDTH-1:0];
`endif

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
`ifdef SIGNED_MUL_EN
        sign_d   = sign_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    mcand_d  = mag_a;
                    mplier_d = mag_b;
                    acc_d    = '0;
                    cnt_d    = CW'(WIDTH);
`ifdef SIGNED_MUL_EN
                    sign_d   = bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
`endif
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                acc_d    = shifted;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d      = DONE;
                    {hi_d, lo_d} = result;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef SIGNED_MUL_EN
            sign_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
`ifdef SIGNED_MUL_EN
            sign_q   <= sign_d;
`endif
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
